// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and small op-classification helpers.
package mdu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle on operand
// magnitudes; done pulses for one cycle once the last bit has been produced.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic            done_q;
  logic [XLEN:0]   shift_c;
  logic [XLEN:0]   diff_c;

  // Partial remainder shifted left by one, then trial subtraction; MSB of diff is the borrow.
  always_comb begin
    shift_c = {rem_q, quo_q[XLEN-1]};
    diff_c  = shift_c - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
    end else if (kill_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        cnt_q <= CW'(XLEN);
        quo_q <= dividend_i;
        rem_q <= '0;
        dvs_q <= divisor_i;
      end else if (cnt_q != '0) begin
        cnt_q  <= cnt_q - CW'(1);
        done_q <= (cnt_q == CW'(1));
        if (!diff_c[XLEN]) begin
          rem_q <= diff_c[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= shift_c[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = done_q;

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO: pipelined multiplier, iterative divider,
// MTHI/MTLO, valid/ready request with a one-cycle done pulse, flushable.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned PW = 2 * XLEN;

  mdu_state_e      state_q;
  logic            req_ready_q;
  logic            busy_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  logic            div_qneg_q;
  logic            div_rneg_q;
  logic            div_dz_q;
  logic [XLEN-1:0] div_s1_q;

  logic            accept_c;
  logic            mul_sgn_c;
  logic            div_sgn_c;
  logic [PW-1:0]   mul_a_c;
  logic [PW-1:0]   mul_b_c;
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] div_a_c;
  logic [XLEN-1:0] div_b_c;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_done;
  logic [XLEN-1:0] quo_fix_c;
  logic [XLEN-1:0] rem_fix_c;

  logic [PW-1:0]      prod_q [MUL_LAT];
  logic [MUL_LAT-1:0] pvld_q;

  // Request decode; flush in the accept cycle discards the request.
  always_comb begin
    accept_c  = req_valid && (state_q == S_IDLE) && !flush;
    mul_sgn_c = (req_op == OP_MULT);
    div_sgn_c = (req_op == OP_DIV);
    mul_a_c   = {{XLEN{mul_sgn_c & src1[XLEN-1]}}, src1};
    mul_b_c   = {{XLEN{mul_sgn_c & src2[XLEN-1]}}, src2};
    prod_c    = mul_a_c * mul_b_c;
    div_a_c   = (div_sgn_c && src1[XLEN-1]) ? (~src1) + XLEN'(1) : src1;
    div_b_c   = (div_sgn_c && src2[XLEN-1]) ? (~src2) + XLEN'(1) : src2;
    quo_fix_c = div_qneg_q ? (~div_quo) + XLEN'(1) : div_quo;
    rem_fix_c = div_rneg_q ? (~div_rem) + XLEN'(1) : div_rem;
  end

  // Valid-tagged product pipe; only the tags need clearing on flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pvld_q <= '0;
    end else begin
      pvld_q[0] <= accept_c && op_is_mul(req_op);
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        pvld_q[i] <= pvld_q[i-1];
      end
    end
    if (accept_c) begin
      prod_q[0] <= prod_c;
    end
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  mdu_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .kill_i     (flush),
    .start_i    (accept_c && op_is_div(req_op)),
    .dividend_i (div_a_c),
    .divisor_i  (div_b_c),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );

  // Control FSM; HI/LO are written on the edge that enters DONE, alongside resp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_qneg_q   <= 1'b0;
      div_rneg_q   <= 1'b0;
      div_dz_q     <= 1'b0;
      div_s1_q     <= '0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (op_is_mul(req_op)) begin
              state_q <= S_MUL;
            end else if (op_is_div(req_op)) begin
              state_q    <= S_DIV;
              div_qneg_q <= div_sgn_c & (src1[XLEN-1] ^ src2[XLEN-1]);
              div_rneg_q <= div_sgn_c & src1[XLEN-1];
              div_dz_q   <= (src2 == '0);
              div_s1_q   <= src1;
            end else begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              if (req_op == OP_MTHI) hi_q <= src1;
              if (req_op == OP_MTLO) lo_q <= src1;
            end
          end
        end
        S_MUL: begin
          if (pvld_q[MUL_LAT-1]) begin
            {hi_q, lo_q} <= prod_q[MUL_LAT-1];
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            if (div_dz_q) begin
              lo_q <= '1;
              hi_q <= div_s1_q;
            end else begin
              lo_q <= quo_fix_c;
              hi_q <= rem_fix_c;
            end
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against an arithmetic reference
// model of HI/LO, latency and the flush/reset rules.
module tb_mdu_iter;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 2;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned resp_seen;
  int unsigned resp_exp;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_iter #(
    .XLEN   (XLEN),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .busy      (busy),
    .resp_valid(resp_valid),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && resp_valid === 1'b1) resp_seen++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result of one op from plain 64-bit arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] h, inout logic [31:0] l);
    longint sp;
    longint sa;
    longint sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin sp = sa * sb; up = 64'(sp); h = up[63:32]; l = up[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = a;
        end else if (op == 3'd2) begin
          sp = sa / sb; up = 64'(sp); l = up[31:0];
          sp = sa % sb; up = 64'(sp); h = up[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return int'(MUL_LAT) + 1;
    if (op == 3'd2 || op == 3'd3) return int'(XLEN) + 2;
    return 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op, measure latency to resp_valid, then compare HI/LO with the model.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    bit stable;
    bit held;
    logic [31:0] eh;
    logic [31:0] el;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    eh = hi_m;
    el = lo_m;
    model_op(op, a, b, eh, el);
    req_valid = 1'b1;
    req_op    = op;
    src1      = a;
    src2      = b;
    step();
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    src1      = $urandom;
    src2      = $urandom;
    n = 1;
    stable = 1'b1;
    held = 1'b1;
    while (resp_valid !== 1'b1 && n < 100) begin
      if (hi !== hi_m || lo !== lo_m) stable = 1'b0;
      if (req_ready !== 1'b0 || busy !== 1'b1) held = 1'b0;
      step();
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(exp_latency(op)));
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    if (exp_latency(op) > 1) begin
      check_eq({tag, "_nopartial"}, 64'(stable), 64'd1);
      check_eq({tag, "_held"}, 64'(held), 64'd1);
    end
    hi_m = eh;
    lo_m = el;
    resp_exp++;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resp_seen = 0;
    resp_exp  = 0;
    hi_m      = '0;
    lo_m      = '0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_resp", 64'(resp_valid), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_z", 3'd3, 32'd5, 32'd0);
    run_op("div_z", 3'd2, 32'hFFFF_FF00, 32'd0);
    run_op("mthi", 3'd4, 32'h1234, 32'd0);
    run_op("mtlo", 3'd5, 32'h5678, 32'd0);
    run_op("nop", 3'd6, 32'hDEAD, 32'hBEEF);

    // Flush during divide iteration: no commit, unit returns to idle.
    req_valid = 1'b1;
    req_op    = 3'd2;
    src1      = 32'd1000;
    src2      = 32'd7;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_ready", 64'(req_ready), 64'd1);
    check_eq("flush_busy", 64'(busy), 64'd0);
    repeat (40) step();
    check_eq("flush_hi", 64'(hi), 64'(hi_m));
    check_eq("flush_lo", 64'(lo), 64'(lo_m));

    // Flush in the accept cycle discards the request.
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = 3'd4;
    src1      = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq("flacc_ready", 64'(req_ready), 64'd1);
    step();
    check_eq("flacc_hi", 64'(hi), 64'(hi_m));

    for (int i = 0; i < 40; i++) begin
      run_op("rnd", 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
    end

    // Reset in the middle of a multiply clears HI/LO and drops the op.
    req_valid = 1'b1;
    req_op    = 3'd1;
    src1      = 32'h1111_1111;
    src2      = 32'h2222_2222;
    step();
    req_valid = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    check_eq("rstmul_busy", 64'(busy), 64'd0);
    check_eq("rstmul_hi", 64'(hi), 64'd0);
    check_eq("rstmul_lo", 64'(lo), 64'd0);
    repeat (6) step();
    check_eq("rstmul_hold_lo", 64'(lo), 64'd0);

    run_op("post_rst", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) step();
    check_eq("resp_count", 64'(resp_seen), 64'(resp_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
